cache_miss_arbiter: RTL

- Sits directly upstream of the cache fill FSM.
- Arbitrates I-cache and D-cache miss requests onto the single fill FSM and shared memory port.
- Latches the winning miss address and holds it for the full line fill.
- Routes the FSM's data/tag write strobes back to the owning cache and generates per-cache stall signals.

---
 rtl/cache_miss_arbiter_pkg.sv | 15 +
 rtl/cache_miss_arbiter_rr_arb2.sv | 21 ++
 rtl/cache_miss_arbiter.sv | 117 +++++++++++
 3 files changed

// File: rtl/cache_miss_arbiter_pkg.sv
// Shared encodings for the cache miss arbiter: FSM states and fill-owner codes.
// Imported by the top module and the round-robin picker.
package cache_miss_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_FILL  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

endpackage

// File: rtl/cache_miss_arbiter_rr_arb2.sv
// Two-input round-robin picker: bit 0 is the I-cache, bit 1 the D-cache.
// On a tie the requester that did not win last time is granted.
module rr_arb2
  import cache_miss_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_grant == OWNER_I) ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/cache_miss_arbiter.sv
// Arbitrates I-/D-cache misses onto one line-fill FSM, holds the winning address
// for the whole fill, routes write strobes to the owner and drives per-cache stalls.
module cache_miss_arbiter
  import cache_miss_arbiter_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              icache_miss,
  input  logic [ADDR_W-1:0] icache_miss_addr,
  input  logic              dcache_miss,
  input  logic [ADDR_W-1:0] dcache_miss_addr,
  input  logic              fill_busy,
  input  logic              fill_write_data,
  input  logic              fill_write_tag,
  output logic              miss_detected,
  output logic [ADDR_W-1:0] miss_address,
  output logic              icache_write_data,
  output logic              icache_write_tag,
  output logic              dcache_write_data,
  output logic              dcache_write_tag,
  output logic              icache_stall,
  output logic              dcache_stall,
  output logic              fill_owner,
  output logic              fill_timeout
);

  localparam int                WDOG_W     = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WDOG_W-1:0] WDOG_MAX   = '1;

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                owner_q;
  logic                last_grant_q;
  logic [WDOG_W-1:0]   wdog_q;
  logic                timeout_q;

  logic [1:0]          req;
  logic [1:0]          grant;
  logic                owner_miss;
  logic                fsm_busy;
  logic                in_fill;

  assign req        = {dcache_miss, icache_miss};
  assign owner_miss = (owner_q == OWNER_D) ? dcache_miss : icache_miss;

  rr_arb2 u_rr_arb2 (
    .req        (req),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      owner_q      <= OWNER_I;
      last_grant_q <= OWNER_I;
      wdog_q       <= '0;
      timeout_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant != 2'b00) begin
            owner_q      <= grant[1];
            last_grant_q <= grant[1];
            addr_q       <= grant[1] ? dcache_miss_addr : icache_miss_addr;
            state_q      <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (fill_busy) begin
            state_q <= ST_FILL;
            wdog_q  <= '0;
          end else if (!owner_miss) begin
            state_q <= ST_IDLE;
          end
        end
        ST_FILL: begin
          if (wdog_q != WDOG_MAX) wdog_q <= wdog_q + 1'b1;
          // A tag write always completes the line, even on the watchdog's last cycle.
          if (fill_write_tag) begin
            state_q <= ST_DRAIN;
          end else if (!fill_busy || (wdog_q == WDOG_LIMIT)) begin
            timeout_q <= 1'b1;
            state_q   <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (!fill_busy) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign fsm_busy      = (state_q != ST_IDLE);
  assign in_fill       = (state_q == ST_FILL);
  assign miss_detected = (state_q == ST_REQ);
  assign miss_address  = fsm_busy ? addr_q : '0;

  assign icache_write_data = in_fill && (owner_q == OWNER_I) && fill_write_data;
  assign icache_write_tag  = in_fill && (owner_q == OWNER_I) && fill_write_tag;
  assign dcache_write_data = in_fill && (owner_q == OWNER_D) && fill_write_data;
  assign dcache_write_tag  = in_fill && (owner_q == OWNER_D) && fill_write_tag;

  // Stalls are held low while reset is asserted so every output is quiet during reset.
  assign icache_stall = rst_n && (icache_miss || (fsm_busy && (owner_q == OWNER_I)));
  assign dcache_stall = rst_n && (dcache_miss || (fsm_busy && (owner_q == OWNER_D)));

  assign fill_owner   = owner_q;
  assign fill_timeout = timeout_q;

endmodule
